// File: rtl/lcd_bus_timing_ctrl.sv
// -----------------------------------------------------------------------------
// lcd_bus_timing_ctrl
//
// Avalon-MM slave (with waitrequest) that converts CPU register accesses into
// HD44780-timed LCD bus cycles. Each access is run as a sequence of counted
// phases:
//
//   IDLE -> SETUP -> E_HIGH -> HOLD -> RECOVER -> [POLL -> poll cycles] -> DONE
//
//   SETUP   : RS/RW (and write data) stable, E low.
//   E_HIGH  : E high; read data is sampled on the last cycle of the pulse.
//   HOLD    : E low, RS/RW/data/oe unchanged.
//   RECOVER : bus released (oe=0, RS=RW=0), guarantees the minimum cycle time.
//   POLL    : after a write, optionally re-run the cycle as a status read
//             (RS=0, RW=1) until the busy flag (bit 7) reads clear or the poll
//             limit is hit.
//   DONE    : waitrequest low for exactly one clock.
//
// The tri-state buffer is built outside this block from LCD_data_out and
// LCD_data_oe.
//
// Ports
//   clk           in   1  system clock
//   reset         in   1  synchronous, active-high reset
//   address       in   2  bit0 = RW (1 read), bit1 = RS (1 data register)
//   read          in   1  Avalon read request
//   write         in   1  Avalon write request (wins over read)
//   writedata     in   8  byte to LCD
//   readdata      out  8  byte sampled from LCD; valid while waitrequest=0 on a read
//   waitrequest   out  1  Avalon stall; low only in DONE
//   busy_timeout  out  1  sticky: a busy poll sequence reached POLL_LIMIT
//   LCD_E         out  1  enable strobe
//   LCD_RS        out  1  register select
//   LCD_RW        out  1  1 read / 0 write
//   LCD_data_out  out  8  data driven towards the LCD
//   LCD_data_oe   out  1  1: drive LCD_data_out onto the pins
//   LCD_data_in   in   8  pin data from the LCD
// -----------------------------------------------------------------------------
module lcd_bus_timing_ctrl #(
  parameter int unsigned T_SETUP    = 3,
  parameter int unsigned T_PULSE    = 12,
  parameter int unsigned T_HOLD     = 2,
  parameter int unsigned T_RECOVER  = 10,
  parameter int unsigned BUSY_POLL  = 1,
  parameter int unsigned POLL_LIMIT = 255,
  parameter int unsigned CNT_W      = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] address,
  input  logic       read,
  input  logic       write,
  input  logic [7:0] writedata,
  output logic [7:0] readdata,
  output logic       waitrequest,
  output logic       busy_timeout,
  output logic       LCD_E,
  output logic       LCD_RS,
  output logic       LCD_RW,
  output logic [7:0] LCD_data_out,
  output logic       LCD_data_oe,
  input  logic [7:0] LCD_data_in
);

  // Phase counters count down from (length-1) to 0; a length of 0 behaves as 1.
  localparam logic [CNT_W-1:0] LD_SETUP   = CNT_W'((T_SETUP   == 0) ? 0 : T_SETUP   - 1);
  localparam logic [CNT_W-1:0] LD_PULSE   = CNT_W'((T_PULSE   == 0) ? 0 : T_PULSE   - 1);
  localparam logic [CNT_W-1:0] LD_HOLD    = CNT_W'((T_HOLD    == 0) ? 0 : T_HOLD    - 1);
  localparam logic [CNT_W-1:0] LD_RECOVER = CNT_W'((T_RECOVER == 0) ? 0 : T_RECOVER - 1);
  localparam logic [CNT_W-1:0] POLL_LIM   = CNT_W'(POLL_LIMIT);
  localparam bit               POLL_EN    = (BUSY_POLL != 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_E_HIGH,
    S_HOLD,
    S_RECOVER,
    S_POLL,
    S_DONE
  } state_e;

  state_e           state_q;
  logic [CNT_W-1:0] phase_cnt_q;
  logic [CNT_W-1:0] poll_cnt_q;
  logic [CNT_W-1:0] poll_cnt_d;
  logic             polling_q;
  logic             op_wr_q;
  logic [7:0]       rd_q;
  logic [7:0]       readdata_q;
  logic             wait_q;
  logic             timeout_q;
  logic             e_q;
  logic             rs_q;
  logic             rw_q;
  logic [7:0]       dout_q;
  logic             oe_q;

  logic             phase_end;

  assign phase_end = (phase_cnt_q == '0);

  // Saturating poll count so a huge POLL_LIMIT cannot wrap the counter.
  assign poll_cnt_d = (poll_cnt_q == '1) ? poll_cnt_q : poll_cnt_q + 1'b1;

  // NOTE: all state lives in this one clocked block and is assigned with <=,
  // so every branch sees the values from before the edge regardless of the
  // order of statements; each register gets a reset value.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      phase_cnt_q <= '0;
      poll_cnt_q  <= '0;
      polling_q   <= 1'b0;
      op_wr_q     <= 1'b0;
      rd_q        <= 8'h00;
      readdata_q  <= 8'h00;
      wait_q      <= 1'b1;
      timeout_q   <= 1'b0;
      e_q         <= 1'b0;
      rs_q        <= 1'b0;
      rw_q        <= 1'b0;
      dout_q      <= 8'h00;
      oe_q        <= 1'b0;
    end else begin
      // waitrequest is low only for the single cycle spent in DONE; the
      // transitions into DONE below override this default.
      wait_q <= 1'b1;

      unique case (state_q)
        S_IDLE: begin
          if (read || write) begin
            op_wr_q     <= write;
            polling_q   <= 1'b0;
            rs_q        <= address[1];
            // RW follows the accepted operation so a write never drives the
            // pins while the LCD is also told to drive them.
            rw_q        <= ~write;
            oe_q        <= write;
            if (write) begin
              dout_q <= writedata;
            end
            phase_cnt_q <= LD_SETUP;
            state_q     <= S_SETUP;
          end
        end

        S_SETUP: begin
          if (phase_end) begin
            e_q         <= 1'b1;
            phase_cnt_q <= LD_PULSE;
            state_q     <= S_E_HIGH;
          end else begin
            phase_cnt_q <= phase_cnt_q - 1'b1;
          end
        end

        S_E_HIGH: begin
          if (phase_end) begin
            e_q <= 1'b0;
            // Sample at the end of the pulse, when LCD read data is valid.
            if (!op_wr_q || polling_q) begin
              rd_q <= LCD_data_in;
            end
            phase_cnt_q <= LD_HOLD;
            state_q     <= S_HOLD;
          end else begin
            phase_cnt_q <= phase_cnt_q - 1'b1;
          end
        end

        S_HOLD: begin
          if (phase_end) begin
            oe_q        <= 1'b0;
            rs_q        <= 1'b0;
            rw_q        <= 1'b0;
            phase_cnt_q <= LD_RECOVER;
            state_q     <= S_RECOVER;
          end else begin
            phase_cnt_q <= phase_cnt_q - 1'b1;
          end
        end

        S_RECOVER: begin
          if (!phase_end) begin
            phase_cnt_q <= phase_cnt_q - 1'b1;
          end else if (polling_q) begin
            if (!rd_q[7]) begin
              // Busy flag clear: the write is complete.
              wait_q  <= 1'b0;
              state_q <= S_DONE;
            end else begin
              poll_cnt_q <= poll_cnt_d;
              if (poll_cnt_d >= POLL_LIM) begin
                timeout_q <= 1'b1;
                wait_q    <= 1'b0;
                state_q   <= S_DONE;
              end else begin
                // Another status read straight away.
                rw_q        <= 1'b1;
                phase_cnt_q <= LD_SETUP;
                state_q     <= S_SETUP;
              end
            end
          end else if (op_wr_q && POLL_EN) begin
            state_q <= S_POLL;
          end else begin
            if (!op_wr_q) begin
              readdata_q <= rd_q;
            end
            wait_q  <= 1'b0;
            state_q <= S_DONE;
          end
        end

        S_POLL: begin
          // Status read: RS=0, RW=1, pins released. The polled byte stays
          // internal and never reaches readdata.
          polling_q   <= 1'b1;
          poll_cnt_q  <= '0;
          rs_q        <= 1'b0;
          rw_q        <= 1'b1;
          oe_q        <= 1'b0;
          phase_cnt_q <= LD_SETUP;
          state_q     <= S_SETUP;
        end

        S_DONE: begin
          state_q <= S_IDLE;
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign readdata     = readdata_q;
  assign waitrequest  = wait_q;
  assign busy_timeout = timeout_q;
  assign LCD_E        = e_q;
  assign LCD_RS       = rs_q;
  assign LCD_RW       = rw_q;
  assign LCD_data_out = dout_q;
  assign LCD_data_oe  = oe_q;

endmodule
